// File: rtl/core_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arb_pkg
// Purpose  : Shared definitions for the unified memory-port arbiter: FSM state
//            encoding, requester (owner) encoding and a ceil-log2 helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package core_mem_arb_pkg;

   // Arbiter FSM states
   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_ISSUE = 2'd1;
   localparam logic [1:0] c_ST_WAIT  = 2'd2;
   localparam logic [1:0] c_ST_RESP  = 2'd3;

   // Requester that owns the in-flight access
   localparam logic c_OWN_IF  = 1'b0;
   localparam logic c_OWN_LSU = 1'b1;

   // Ceiling log2; returns 0 for values <= 1
   function automatic int clog2(input int value);
      int v;
      int r;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage : core_mem_arb_pkg
`default_nettype wire

// File: rtl/core_mem_arb_sel.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arb_sel
// Purpose  : Combinational two-requester grant selector. Fixed LSU priority,
//            or round-robin against the last-granted owner when rr_mode is set.
// Ports    : if_req, lsu_req - request bits
//            last_own        - owner granted most recently
//            rr_mode         - 1 = round-robin, 0 = fixed LSU priority
//            grant           - selected owner (c_OWN_IF / c_OWN_LSU)
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_arb_sel
   import core_mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic lsu_req,
   input  logic last_own,
   input  logic rr_mode,
   output logic grant
);

   always_comb begin
      grant = c_OWN_IF;
      if (if_req && lsu_req) begin
         // Contention: round-robin favours whoever was not served last
         grant = rr_mode ? ~last_own : c_OWN_LSU;
      end else if (lsu_req) begin
         grant = c_OWN_LSU;
      end
   end

endmodule : core_mem_arb_sel
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter
// Purpose  : Shares one single-ported memory between the instruction-fetch
//            (IF) and load/store (LSU) requesters, one access outstanding at a
//            time, with an optional per-access response timeout.
//            Build option: CORE_MEM_ARB_RR_EN selects round-robin arbitration
//            (default is fixed LSU priority).
// Ports    : CLK, RSTN (async, active-low)
//            if_*  / lsu_* - requester side: req/addr/wdata/wen in,
//                            ready (comb), rdata, rvld out
//            mem_* - memory side: en/addr/wdata/wen out, rdata/rvld in
//            err_timeout - one-cycle pulse when an access is aborted
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter
   import core_mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int STRB_WIDTH     = DATA_WIDTH / BYTE_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic [DATA_WIDTH-1:0] if_wdata,
   input  logic [STRB_WIDTH-1:0] if_wen,
   output logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_rvld,
   input  logic                  lsu_req,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   input  logic [STRB_WIDTH-1:0] lsu_wen,
   output logic                  lsu_ready,
   output logic [DATA_WIDTH-1:0] lsu_rdata,
   output logic                  lsu_rvld,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [STRB_WIDTH-1:0] mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rvld,
   output logic                  err_timeout
);

   logic [1:0]            r_state;
   logic                  r_owner;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wen;
   logic [DATA_WIDTH-1:0] r_if_rdata;
   logic [DATA_WIDTH-1:0] r_lsu_rdata;
   logic                  r_err;

   logic                  w_grant;
   logic                  w_last;
   logic                  w_rr_mode;
   logic                  w_idle;
   logic                  w_accept;
   logic                  w_to_hit;
   logic [DATA_WIDTH-1:0] w_resp_data;

   // ---------------------------------------------------------------- arbitration
`ifdef CORE_MEM_ARB_RR_EN
   logic r_last;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_last <= c_OWN_IF;
      end else if (w_accept) begin
         r_last <= w_grant;
      end
   end

   assign w_last    = r_last;
   assign w_rr_mode = 1'b1;
`else
   assign w_last    = c_OWN_IF;
   assign w_rr_mode = 1'b0;
`endif

   core_mem_arb_sel u_sel (
      .if_req   (if_req),
      .lsu_req  (lsu_req),
      .last_own (w_last),
      .rr_mode  (w_rr_mode),
      .grant    (w_grant)
   );

   assign w_idle    = (r_state == c_ST_IDLE);
   assign if_ready  = w_idle && if_req  && (w_grant == c_OWN_IF);
   assign lsu_ready = w_idle && lsu_req && (w_grant == c_OWN_LSU);
   assign w_accept  = if_ready || lsu_ready;

   // ------------------------------------------------------------------- timeout
   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         localparam int                 c_CNT_W    = clog2(TIMEOUT_CYCLES + 1);
         localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
         logic [c_CNT_W-1:0]            r_cnt;

         // Cleared during ISSUE so it reads 0 on the first WAIT cycle
         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               r_cnt <= '0;
            end else if (r_state == c_ST_ISSUE) begin
               r_cnt <= '0;
            end else if (r_state == c_ST_WAIT) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_to_hit = (r_state == c_ST_WAIT) && (r_cnt == c_CNT_LAST);
      end else begin : g_no_timeout
         assign w_to_hit = 1'b0;
      end
   endgenerate

   // An aborted access returns zero data to its owner
   assign w_resp_data = mem_rvld ? mem_rdata : '0;

   // ----------------------------------------------------------------------- FSM
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state     <= c_ST_IDLE;
         r_owner     <= c_OWN_IF;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wen       <= '0;
         r_if_rdata  <= '0;
         r_lsu_rdata <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_owner <= w_grant;
                  if (w_grant == c_OWN_LSU) begin
                     r_addr  <= lsu_addr;
                     r_wdata <= lsu_wdata;
                     r_wen   <= lsu_wen;
                  end else begin
                     r_addr  <= if_addr;
                     r_wdata <= if_wdata;
                     r_wen   <= if_wen;
                  end
                  r_state <= c_ST_ISSUE;
               end
            end
            c_ST_ISSUE: begin
               r_state <= c_ST_WAIT;
            end
            c_ST_WAIT: begin
               // A real response takes precedence over a same-cycle timeout
               if (mem_rvld || w_to_hit) begin
                  if (r_owner == c_OWN_LSU) begin
                     r_lsu_rdata <= w_resp_data;
                  end else begin
                     r_if_rdata <= w_resp_data;
                  end
                  r_err   <= !mem_rvld;
                  r_state <= c_ST_RESP;
               end
            end
            c_ST_RESP: begin
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------- outputs
   assign mem_en      = (r_state == c_ST_ISSUE);
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign mem_wen     = r_wen;
   assign if_rdata    = r_if_rdata;
   assign lsu_rdata   = r_lsu_rdata;
   assign if_rvld     = (r_state == c_ST_RESP) && (r_owner == c_OWN_IF);
   assign lsu_rvld    = (r_state == c_ST_RESP) && (r_owner == c_OWN_LSU);
   assign err_timeout = r_err;

endmodule : core_mem_arbiter
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_arbiter
// Purpose  : Directed self-checking bench. Instance A has the timeout
//            disabled (TIMEOUT_CYCLES=0); instance B uses TIMEOUT_CYCLES=4.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

   logic CLK;
   logic RSTN;

   // Instance A
   logic        a_if_req,  a_lsu_req;
   logic [31:0] a_if_addr, a_if_wdata, a_lsu_addr, a_lsu_wdata;
   logic [3:0]  a_if_wen,  a_lsu_wen;
   logic        a_if_ready, a_if_rvld, a_lsu_ready, a_lsu_rvld;
   logic [31:0] a_if_rdata, a_lsu_rdata;
   logic        a_mem_en, a_mem_rvld, a_err;
   logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [3:0]  a_mem_wen;

   // Instance B (IF side only)
   logic        b_if_req;
   logic [31:0] b_if_addr;
   logic        b_if_ready, b_if_rvld, b_lsu_ready, b_lsu_rvld;
   logic [31:0] b_if_rdata, b_lsu_rdata;
   logic        b_mem_en, b_mem_rvld, b_err;
   logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [3:0]  b_mem_wen;

   int n_checks = 0;
   int n_fail   = 0;

   core_mem_arbiter #(.TIMEOUT_CYCLES(0)) u_dut_a (
      .CLK(CLK), .RSTN(RSTN),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_wdata(a_if_wdata), .if_wen(a_if_wen),
      .if_ready(a_if_ready), .if_rdata(a_if_rdata), .if_rvld(a_if_rvld),
      .lsu_req(a_lsu_req), .lsu_addr(a_lsu_addr), .lsu_wdata(a_lsu_wdata), .lsu_wen(a_lsu_wen),
      .lsu_ready(a_lsu_ready), .lsu_rdata(a_lsu_rdata), .lsu_rvld(a_lsu_rvld),
      .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wen(a_mem_wen),
      .mem_rdata(a_mem_rdata), .mem_rvld(a_mem_rvld), .err_timeout(a_err)
   );

   core_mem_arbiter #(.TIMEOUT_CYCLES(4)) u_dut_b (
      .CLK(CLK), .RSTN(RSTN),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_wdata(32'h0), .if_wen(4'h0),
      .if_ready(b_if_ready), .if_rdata(b_if_rdata), .if_rvld(b_if_rvld),
      .lsu_req(1'b0), .lsu_addr(32'h0), .lsu_wdata(32'h0), .lsu_wen(4'h0),
      .lsu_ready(b_lsu_ready), .lsu_rdata(b_lsu_rdata), .lsu_rvld(b_lsu_rvld),
      .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wen(b_mem_wen),
      .mem_rdata(b_mem_rdata), .mem_rvld(b_mem_rvld), .err_timeout(b_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One complete access on instance A with memory latency lat (>=1)
   task automatic access_a(input bit lsu, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] wen, input int lat, input logic [31:0] rd);
      if (lsu) begin
         a_lsu_req = 1'b1; a_lsu_addr = addr; a_lsu_wdata = wd; a_lsu_wen = wen;
      end else begin
         a_if_req = 1'b1;  a_if_addr = addr;  a_if_wdata = wd;  a_if_wen = wen;
      end
      #1;
      check("acc_ready", lsu ? a_lsu_ready : a_if_ready, 32'd1);
      check("acc_other_ready", lsu ? a_if_ready : a_lsu_ready, 32'd0);
      tick();
      a_if_req = 1'b0; a_lsu_req = 1'b0;
      #1;
      check("acc_mem_en_issue", a_mem_en, 32'd1);
      check("acc_mem_addr_issue", a_mem_addr, addr);
      check("acc_mem_wdata", a_mem_wdata, wd);
      check("acc_mem_wen", a_mem_wen, wen);
      for (int k = 0; k < lat; k++) begin
         tick();
         check("acc_mem_en_wait", a_mem_en, 32'd0);
         check("acc_rvld_wait", {a_if_rvld, a_lsu_rvld}, 32'd0);
         check("acc_mem_addr_wait", a_mem_addr, addr);
      end
      a_mem_rvld = 1'b1; a_mem_rdata = rd;
      tick();
      a_mem_rvld = 1'b0; a_mem_rdata = 32'h0;
      #1;
      check("acc_owner_rvld", lsu ? a_lsu_rvld : a_if_rvld, 32'd1);
      check("acc_other_rvld", lsu ? a_if_rvld : a_lsu_rvld, 32'd0);
      check("acc_rdata", lsu ? a_lsu_rdata : a_if_rdata, rd);
      check("acc_mem_addr_resp", a_mem_addr, addr);
      tick();
      check("acc_rvld_idle", {a_if_rvld, a_lsu_rvld}, 32'd0);
   endtask

   initial begin
      bit exp_lsu;
      RSTN = 1'b0;
      a_if_req = 0; a_if_addr = 0; a_if_wdata = 0; a_if_wen = 0;
      a_lsu_req = 0; a_lsu_addr = 0; a_lsu_wdata = 0; a_lsu_wen = 0;
      a_mem_rdata = 0; a_mem_rvld = 0;
      b_if_req = 0; b_if_addr = 0; b_mem_rdata = 0; b_mem_rvld = 0;

      // Reset state
      tick(); tick();
      check("rst_mem_en", a_mem_en, 32'd0);
      check("rst_mem_addr", a_mem_addr, 32'd0);
      check("rst_rvld", {a_if_rvld, a_lsu_rvld, a_err}, 32'd0);
      check("rst_rdata", a_if_rdata | a_lsu_rdata, 32'd0);
      RSTN = 1'b1;
      tick();

      // IF read, L=1
      access_a(1'b0, 32'hFFFF_0010, 32'h0, 4'h0, 1, 32'h0000_0013);
      check("if_rdata_hold", a_if_rdata, 32'h0000_0013);

      // Simultaneous requests: LSU write wins, IF served on the next IDLE
      a_lsu_req = 1; a_lsu_addr = 32'hFFFF_1004; a_lsu_wdata = 32'hDEAD_BEEF; a_lsu_wen = 4'hF;
      a_if_req = 1;  a_if_addr = 32'hFFFF_0020;  a_if_wdata = 32'h0;         a_if_wen = 4'h0;
      #1;
      check("arb_lsu_ready", a_lsu_ready, 32'd1);
      check("arb_if_ready", a_if_ready, 32'd0);
      tick();
      a_lsu_req = 0;
      #1;
      check("arb_wr_addr", a_mem_addr, 32'hFFFF_1004);
      check("arb_wr_data", a_mem_wdata, 32'hDEAD_BEEF);
      check("arb_wr_wen", a_mem_wen, 32'hF);
      check("arb_if_ready_busy", a_if_ready, 32'd0);
      tick();
      a_mem_rvld = 1; a_mem_rdata = 32'h0;
      tick();
      a_mem_rvld = 0;
      #1;
      check("arb_lsu_rvld", a_lsu_rvld, 32'd1);
      check("arb_if_rvld", a_if_rvld, 32'd0);
      tick();
      check("arb_if_ready_next", a_if_ready, 32'd1);
      tick();
      a_if_req = 0;
      #1;
      check("arb_if_addr", a_mem_addr, 32'hFFFF_0020);
      check("arb_if_mem_en", a_mem_en, 32'd1);
      tick();
      a_mem_rvld = 1; a_mem_rdata = 32'h0000_0077;
      tick();
      a_mem_rvld = 0;
      #1;
      check("arb_if_rvld2", a_if_rvld, 32'd1);
      check("arb_if_rdata2", a_if_rdata, 32'h0000_0077);
      tick();

      // Both requesters held continuously over four accesses
      a_lsu_req = 1; a_lsu_addr = 32'h0000_1000; a_lsu_wen = 4'h0;
      a_if_req = 1;  a_if_addr = 32'h0000_2000;
      #1;
      for (int i = 0; i < 4; i++) begin
`ifdef CORE_MEM_ARB_RR_EN
         exp_lsu = ((i % 2) == 0);
`else
         exp_lsu = 1'b1;
`endif
         check("hold_lsu_ready", a_lsu_ready, {31'd0, exp_lsu});
         check("hold_if_ready", a_if_ready, {31'd0, !exp_lsu});
         tick();
         check("hold_addr", a_mem_addr, exp_lsu ? 32'h0000_1000 : 32'h0000_2000);
         tick();
         a_mem_rvld = 1; a_mem_rdata = 32'h100 + i;
         tick();
         a_mem_rvld = 0;
         #1;
         check("hold_rvld", {a_lsu_rvld, a_if_rvld}, exp_lsu ? 32'd2 : 32'd1);
         tick();
      end
      a_lsu_req = 0; a_if_req = 0;
      tick();

      // Back-to-back LSU reads with varying latency
      access_a(1'b1, 32'h0000_0100, 32'h0, 4'h0, 1,  32'hA5A5_0001);
      access_a(1'b1, 32'h0000_0104, 32'h0, 4'h0, 5,  32'hA5A5_0005);
      access_a(1'b1, 32'h0000_0108, 32'h0, 4'h0, 17, 32'hA5A5_0017);

      // Timeout disabled: L=200 still completes at cycle 202
      access_a(1'b0, 32'h0000_0200, 32'h0, 4'h0, 200, 32'hC0DE_0200);

      // Reset during WAIT drops the access
      a_lsu_req = 1; a_lsu_addr = 32'h0000_0040; a_lsu_wen = 4'h0;
      tick();
      a_lsu_req = 0;
      tick(); tick();
      RSTN = 0;
      #1;
      check("rstw_mem_en", a_mem_en, 32'd0);
      check("rstw_mem_addr", a_mem_addr, 32'd0);
      check("rstw_lsu_rdata", a_lsu_rdata, 32'd0);
      check("rstw_if_rdata", a_if_rdata, 32'd0);
      tick();
      RSTN = 1; a_mem_rvld = 1; a_mem_rdata = 32'h1111_1111;
      tick();
      a_mem_rvld = 0;
      #1;
      check("rstw_no_rvld", {a_if_rvld, a_lsu_rvld}, 32'd0);
      check("rstw_lsu_rdata2", a_lsu_rdata, 32'd0);
      a_if_req = 1; a_if_addr = 32'h0000_0300;
      #1;
      check("rstw_idle_ready", a_if_ready, 32'd1);
      a_if_req = 0;
      tick();
      check("withdraw_no_issue", a_mem_en, 32'd0);

      // Instance B: normal read, then timeout with TIMEOUT_CYCLES=4
      b_if_req = 1; b_if_addr = 32'h0000_0100;
      #1;
      check("b_ready", b_if_ready, 32'd1);
      tick();
      b_if_req = 0;
      tick();
      b_mem_rvld = 1; b_mem_rdata = 32'h0000_1234;
      tick();
      b_mem_rvld = 0;
      #1;
      check("b_rvld", b_if_rvld, 32'd1);
      check("b_rdata", b_if_rdata, 32'h0000_1234);
      check("b_no_err", b_err, 32'd0);
      tick();

      b_if_req = 1; b_if_addr = 32'h0000_0200;
      #1;
      check("to_ready", b_if_ready, 32'd1);
      tick();
      b_if_req = 0;
      #1;
      check("to_mem_en", b_mem_en, 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("to_wait_quiet", {b_err, b_if_rvld}, 32'd0);
      end
      tick();
      check("to_err", b_err, 32'd1);
      check("to_rvld", b_if_rvld, 32'd1);
      check("to_rdata", b_if_rdata, 32'd0);
      check("to_lsu_rvld", b_lsu_rvld, 32'd0);
      tick();
      check("to_after", {b_err, b_if_rvld, b_mem_en}, 32'd0);
      check("to_idle_ready", b_lsu_ready, 32'd0);
      repeat (9) tick();
      b_mem_rvld = 1; b_mem_rdata = 32'h9999_9999;
      tick();
      b_mem_rvld = 0;
      #1;
      check("late_no_rvld", b_if_rvld, 32'd0);
      tick();
      check("late_no_rvld2", {b_if_rvld, b_err}, 32'd0);
      check("late_rdata", b_if_rdata, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_core_mem_arbiter
`default_nettype wire
